// File: rtl/i2c_slave_core.sv
// I2C slave protocol core: filtered SCL/SDA decode, address match, byte write/read with ACK/NACK.
// Optional build macro I2C_SLAVE_GENCALL_EN additionally ACKs the general-call address (0x00, write).
module i2c_slave_core #(
    parameter int MAX_BYTES  = 16,
    parameter int FILTER_CYC = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             scl_i,
    input  logic                             sda_i,
    output logic                             sda_oe,
    input  logic [6:0]                       slave_addr,
    output logic [7:0]                       rx_data,
    output logic                             rx_valid,
    input  logic [7:0]                       tx_data,
    output logic                             tx_req,
    output logic                             busy,
    output logic [$clog2(MAX_BYTES+1)-1:0]   byte_cnt
);
    localparam int BCW = $clog2(MAX_BYTES + 1);
    localparam int FCW = (FILTER_CYC > 1) ? $clog2(FILTER_CYC) : 1;
    localparam logic [BCW-1:0] MAX_B   = BCW'(MAX_BYTES);
    localparam logic [FCW-1:0] FLT_TOP = FCW'(FILTER_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    // index 1 = SCL, index 0 = SDA
    logic [1:0]          raw, s1, s2, filt, filt_q;
    logic [1:0][FCW-1:0] fcnt;
    assign raw = {scl_i, sda_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= '1;
            s2     <= '1;
            filt   <= '1;
            filt_q <= '1;
            fcnt   <= '0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i])
                    fcnt[i] <= '0;
                else if (fcnt[i] == FLT_TOP) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else
                    fcnt[i] <= fcnt[i] + FCW'(1);
            end
        end
    end

    logic sda_f, scl_rise, scl_fall, start, stop;
    assign sda_f    = filt[0];
    assign scl_rise = filt[1] & ~filt_q[1];
    assign scl_fall = ~filt[1] & filt_q[1];
    assign start    = filt[1] & filt_q[1] & filt_q[0] & ~filt[0];
    assign stop     = filt[1] & filt_q[1] & ~filt_q[0] & filt[0];

    state_t         state, state_nx;
    logic [3:0]     bit_cnt, bit_nx;
    logic [7:0]     sr, sr_nx, tx_sr, txs_nx, rxd_nx;
    logic           rw, rw_nx, oe_nx, busy_nx, rxv_nx, txr_nx, mack, mack_nx, tx_load;
    logic [BCW-1:0] bc_nx;
    logic           addr_hit;

`ifdef I2C_SLAVE_GENCALL_EN
    assign addr_hit = (sr[7:1] == slave_addr) || (sr == 8'h00);
`else
    assign addr_hit = (sr[7:1] == slave_addr);
`endif

    always_comb begin
        state_nx = state;
        bit_nx   = bit_cnt;
        sr_nx    = sr;
        rw_nx    = rw;
        oe_nx    = sda_oe;
        busy_nx  = busy;
        bc_nx    = byte_cnt;
        rxd_nx   = rx_data;
        rxv_nx   = 1'b0;
        txr_nx   = 1'b0;
        mack_nx  = mack;
        txs_nx   = tx_load ? tx_data : tx_sr;
        if (start) begin
            state_nx = ADDR;
            bit_nx   = '0;
            bc_nx    = '0;
            oe_nx    = 1'b0;
            busy_nx  = 1'b0;
        end else if (stop) begin
            state_nx = IDLE;
            oe_nx    = 1'b0;
            busy_nx  = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        sr_nx  = {sr[6:0], sda_f};
                        bit_nx = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (addr_hit) begin
                            state_nx = ADDR_ACK;
                            oe_nx    = 1'b1;
                            busy_nx  = 1'b1;
                            rw_nx    = sr[0];
                        end else
                            state_nx = WAIT_STOP;
                    end
                end
                ADDR_ACK: begin
                    // request read data during the ACK clock so it is loaded before SCL falls
                    if (scl_rise && rw)
                        txr_nx = 1'b1;
                    else if (scl_fall) begin
                        bit_nx   = '0;
                        state_nx = rw ? RD_DATA : WR_DATA;
                        oe_nx    = rw ? ~tx_sr[7] : 1'b0;
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        sr_nx  = {sr[6:0], sda_f};
                        bit_nx = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rxd_nx = {sr[6:0], sda_f};
                            rxv_nx = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_nx = WR_ACK;
                        if (byte_cnt < MAX_B) begin
                            oe_nx = 1'b1;
                            bc_nx = byte_cnt + BCW'(1);
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        oe_nx    = 1'b0;
                        bit_nx   = '0;
                        state_nx = sda_oe ? WR_DATA : WAIT_STOP;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd7) begin
                            state_nx = RD_ACK;
                            oe_nx    = 1'b0;
                        end else begin
                            bit_nx = bit_cnt + 4'd1;
                            txs_nx = {tx_sr[6:0], 1'b0};
                            oe_nx  = ~tx_sr[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        mack_nx = ~sda_f;
                        if (!sda_f) begin
                            txr_nx = 1'b1;
                            if (byte_cnt < MAX_B)
                                bc_nx = byte_cnt + BCW'(1);
                        end
                    end else if (scl_fall) begin
                        bit_nx   = '0;
                        state_nx = mack ? RD_DATA : WAIT_STOP;
                        oe_nx    = mack & ~tx_sr[7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            sr       <= '0;
            rw       <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            byte_cnt <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            tx_load  <= 1'b0;
            tx_sr    <= '0;
            mack     <= 1'b0;
        end else begin
            state    <= state_nx;
            bit_cnt  <= bit_nx;
            sr       <= sr_nx;
            rw       <= rw_nx;
            sda_oe   <= oe_nx;
            busy     <= busy_nx;
            byte_cnt <= bc_nx;
            rx_data  <= rxd_nx;
            rx_valid <= rxv_nx;
            tx_req   <= txr_nx;
            tx_load  <= txr_nx;
            tx_sr    <= txs_nx;
            mack     <= mack_nx;
        end
    end
endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: bit-level I2C master, open-drain bus and a transaction-level expectation model.
module tb_i2c_slave_core;
    localparam int MAXB = 2;
    localparam int Q    = 8;
    localparam int BCW  = $clog2(MAXB + 1);
    localparam logic [6:0] SADDR = 7'h42;
`ifdef I2C_SLAVE_GENCALL_EN
    localparam bit GENCALL = 1'b1;
`else
    localparam bit GENCALL = 1'b0;
`endif

    logic           clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
    logic           sda_bus, sda_oe, rx_valid, tx_req, busy;
    logic [7:0]     rx_data;
    logic [7:0]     tx_data = 8'h00;
    logic [BCW-1:0] byte_cnt;
    logic [7:0]     glitch_mask = 8'h00;
    logic [7:0]     q_data[$];

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_core #(.MAX_BYTES(MAXB), .FILTER_CYC(2)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
        .slave_addr(SADDR), .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_req(tx_req), .busy(busy), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int n_txreq = 0, n_oe = 0;
    logic [7:0] rxq[$];

    always @(negedge clk) begin
        if (rx_valid) rxq.push_back(rx_data);
        if (tx_req) n_txreq++;
        if (sda_oe) n_oe++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic bit addr_hit(input logic [7:0] a);
        return (a[7:1] == SADDR) || (GENCALL && a == 8'h00);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, input logic g, output logic line);
        cyc(Q); sda_m = b;
        cyc(Q); scl_m = 1'b1;
        cyc(Q/2);
        if (g) begin sda_m = ~b; cyc(1); sda_m = b; end
        cyc(Q/2); line = sda_bus;
        cyc(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_start;
        cyc(Q); sda_m = 1'b1;
        cyc(Q); scl_m = 1'b1;
        cyc(Q); sda_m = 1'b0;
        cyc(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_stop;
        cyc(Q); sda_m = 1'b0;
        cyc(Q); scl_m = 1'b1;
        cyc(Q); sda_m = 1'b1;
        cyc(2*Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic l;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], glitch_mask[i], l);
        clk_bit(1'b1, 1'b0, l);
        ack = ~l;
    endtask

    task automatic rd_byte(input logic m_ack, input logic [7:0] next_tx, output logic [7:0] d);
        logic l;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, 1'b0, l);
            d[i] = l;
        end
        tx_data = next_tx;
        clk_bit(~m_ack, 1'b0, l);
    endtask

    // Write transaction: address byte then q_data; expectations from the ACK/limit rules.
    task automatic run_write(input logic [7:0] a, input bit no_stop);
        bit hit;
        int rx0, oe0, n, n_rx;
        logic ack;
        hit = addr_hit(a);
        rx0 = rxq.size();
        oe0 = n_oe;
        n   = q_data.size();
        i2c_start; cyc(2);
        chk("wr_bc_clr", 32'(byte_cnt), 32'd0);
        wr_byte(a, ack);
        chk("wr_addr_ack", 32'(ack), 32'(hit));
        chk("wr_busy", 32'(busy), 32'(hit));
        for (int i = 0; i < n; i++) begin
            wr_byte(q_data[i], ack);
            chk("wr_data_ack", 32'(ack), 32'(hit && i < MAXB));
        end
        n_rx = hit ? imin(n, MAXB + 1) : 0;
        chk("wr_rx_cnt", 32'(rxq.size() - rx0), 32'(n_rx));
        for (int i = 0; i < n_rx && rx0 + i < rxq.size(); i++)
            chk("wr_rx_data", 32'(rxq[rx0 + i]), 32'(q_data[i]));
        chk("wr_byte_cnt", 32'(byte_cnt), 32'(hit ? imin(n, MAXB) : 0));
        if (!hit) chk("wr_oe_quiet", 32'(n_oe - oe0), 32'd0);
        if (!no_stop) begin
            i2c_stop;
            chk("wr_busy_stop", 32'(busy), 32'd0);
        end
    endtask

    // Read transaction: slave returns q_data, master ACKs all but the last byte.
    task automatic run_read(input logic [7:0] a);
        bit hit;
        int t0, n;
        logic ack;
        logic [7:0] d;
        hit = addr_hit(a);
        t0 = n_txreq;
        n  = q_data.size();
        tx_data = q_data[0];
        i2c_start; cyc(2);
        chk("rd_bc_clr", 32'(byte_cnt), 32'd0);
        wr_byte(a, ack);
        chk("rd_addr_ack", 32'(ack), 32'(hit));
        chk("rd_busy", 32'(busy), 32'(hit));
        for (int i = 0; i < n; i++) begin
            rd_byte(i < n - 1, (i + 1 < n) ? q_data[i + 1] : 8'h00, d);
            chk("rd_data", 32'(d), 32'(hit ? q_data[i] : 8'hFF));
        end
        i2c_stop;
        chk("rd_tx_req_cnt", 32'(n_txreq - t0), 32'(hit ? n : 0));
        chk("rd_byte_cnt", 32'(byte_cnt), 32'(hit ? imin(n - 1, MAXB) : 0));
        chk("rd_busy_stop", 32'(busy), 32'd0);
    endtask

    initial begin
        logic ack, l;
        int t0, oe0, rx0;
        logic [6:0] a7;

        rst = 1'b1;
        cyc(3);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_req", 32'(tx_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        rst = 1'b0;
        cyc(10);

        // basic write, mismatch, read, overflow
        q_data.delete(); q_data.push_back(8'hA5);
        run_write(8'h84, 1'b0);
        q_data.delete(); q_data.push_back(8'h11); q_data.push_back(8'h22);
        run_write(8'h86, 1'b0);
        q_data.delete(); q_data.push_back(8'h3C); q_data.push_back(8'hC3);
        run_read(8'h85);
        q_data.delete(); q_data.push_back(8'h01); q_data.push_back(8'h02); q_data.push_back(8'h03);
        run_write(8'h84, 1'b0);

        // glitched data bits, then repeated START into a read
        glitch_mask = 8'hFF;
        q_data.delete(); q_data.push_back(8'h5A);
        run_write(8'h84, 1'b1);
        glitch_mask = 8'h00;
        chk("glitch_busy", 32'(busy), 32'd1);
        q_data.delete(); q_data.push_back(8'h96);
        run_read(8'h85);

        // reset while the slave drives a 0 data bit
        t0 = n_txreq;
        tx_data = 8'h00;
        i2c_start;
        wr_byte(8'h85, ack);
        chk("rr_addr_ack", 32'(ack), 32'd1);
        cyc(Q); sda_m = 1'b1;
        cyc(Q); scl_m = 1'b1;
        cyc(Q);
        chk("rr_drive", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        #1;
        chk("rr_oe_async", 32'(sda_oe), 32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        oe0 = n_oe;
        rx0 = rxq.size();
        cyc(Q - 1); scl_m = 1'b0;
        for (int i = 0; i < 8; i++) clk_bit(1'b0, 1'b0, l);
        clk_bit(1'b1, 1'b0, l);
        chk("rr_ignored_ack", 32'(l), 32'd1);
        i2c_stop;
        chk("rr_oe_quiet", 32'(n_oe - oe0), 32'd0);
        chk("rr_rx_quiet", 32'(rxq.size() - rx0), 32'd0);
        chk("rr_tx_req", 32'(n_txreq - t0), 32'd1);

        // general call write and read-to-zero
        q_data.delete(); q_data.push_back(8'h77);
        run_write(8'h00, 1'b0);
        q_data.delete(); q_data.push_back(8'h12);
        run_read(8'h01);

        // randomized transactions
        repeat (12) begin
            case ($urandom_range(0, 3))
                0:       a7 = 7'($urandom);
                1:       a7 = 7'h00;
                default: a7 = SADDR;
            endcase
            q_data.delete();
            repeat ($urandom_range(1, 3)) q_data.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 0) run_write({a7, 1'b0}, 1'b0);
            else                           run_read({a7, 1'b1});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
